bcedn_adapter_sched: RTL

Frame-level scheduler that sequences the full-precision adapter datapath for one input image. It streams a zero-padded raster of pixels from the frame buffer into the input window shift register. After every pixel that completes a convolution window, it pauses the stream and steps the weight/norm-ref ROMs through all filter groups. It then presents the assembled FD-bit feature vector to the downstream encoder block under a valid/ready handshake.

---
 rtl/bcedn_sched_pkg.sv | 31 +++
 rtl/bcedn_raster_cnt.sv | 70 +++++++
 rtl/bcedn_adapter_sched.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bcedn_sched_pkg.sv
// Shared definitions for the adapter frame scheduler: default geometry,
// FSM state encodings and width helpers.
package bcedn_sched_pkg;

    localparam int DEF_H     = 32;
    localparam int DEF_W     = 128;
    localparam int DEF_PAD   = 1;
    localparam int DEF_FH    = 3;
    localparam int DEF_FW    = 3;
    localparam int DEF_N_PE  = 1;
    localparam int DEF_DW    = 17;

    // Padded frame size and ROM depth of the default configuration
    localparam int HP        = DEF_H + 2 * DEF_PAD;
    localparam int WP        = DEF_W + 2 * DEF_PAD;
    localparam int DEPTH     = 128;
    localparam int DEF_FD    = DEPTH * DEF_N_PE;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_STREAM  = 2'd1;
    localparam state_t ST_COMPUTE = 2'd2;
    localparam state_t ST_EMIT    = 2'd3;

    // Bits needed to index n items, never less than one
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcedn_raster_cnt.sv
// Padded raster walker: tracks (row, col) over the zero-padded frame and the
// running frame-buffer address of the next data beat.
module bcedn_raster_cnt
    import bcedn_sched_pkg::*;
#(
    parameter int H    = DEF_H,
    parameter int W    = DEF_W,
    parameter int PAD  = DEF_PAD,
    parameter int FH   = DEF_FH,
    parameter int FW   = DEF_FW,
    parameter int HP_P = HP,
    parameter int WP_P = WP
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_advance,
    input  logic                         i_clear,
    output logic                         o_is_pad,
    output logic                         o_win_done,
    output logic                         o_last_beat,
    output logic [width_of(H*W)-1:0]     o_mem_addr
);

    localparam int RW = width_of(HP_P);
    localparam int CW = width_of(WP_P);
    localparam int AW = width_of(H * W);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [AW-1:0] r_addr;
    logic          w_row_end;
    logic          w_col_end;

    assign w_row_end   = (int'(r_row) == HP_P - 1);
    assign w_col_end   = (int'(r_col) == WP_P - 1);
    assign o_last_beat = w_row_end && w_col_end;
    assign o_is_pad    = (int'(r_row) < PAD) || (int'(r_row) >= H + PAD) ||
                         (int'(r_col) < PAD) || (int'(r_col) >= W + PAD);
    assign o_win_done  = (int'(r_row) >= FH - 1) && (int'(r_col) >= FW - 1);
    // Data beats arrive in raster order, so their address is just a running count
    assign o_mem_addr  = r_addr;

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values; the later assignment in the block wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= '0;
        end else if (i_clear) begin
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= '0;
        end else if (i_advance) begin
            if (!o_is_pad) begin
                r_addr <= r_addr + 1'b1;
            end
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
            if (o_last_beat) begin
                r_addr <= '0;
            end
        end
    end

endmodule

// File: rtl/bcedn_adapter_sched.sv
// Frame scheduler: streams the padded raster into the window shift register,
// steps the weight ROMs per window and hands each feature vector downstream.
module bcedn_adapter_sched
    import bcedn_sched_pkg::*;
#(
    parameter int H                = DEF_H,
    parameter int W                = DEF_W,
    parameter int PAD              = DEF_PAD,
    parameter int FH               = DEF_FH,
    parameter int FW               = DEF_FW,
    parameter int FD               = DEF_FD,
    parameter int N_PE             = DEF_N_PE,
    parameter int DATA_IN_FP_WIDTH = DEF_DW
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    output logic                                  mem_rd_en,
    output logic [width_of(H*W)-1:0]              mem_addr,
    input  logic [DATA_IN_FP_WIDTH-1:0]           mem_rd_data,
    output logic [DATA_IN_FP_WIDTH-1:0]           pix_out,
    output logic                                  pix_valid,
    output logic                                  pad_sel,
    output logic                                  rom_en,
    output logic [width_of(FD/N_PE)-1:0]          rom_addr,
    output logic                                  shreg_en,
    output logic                                  vec_valid,
    input  logic                                  out_ready,
    output logic                                  busy,
    output logic                                  frame_done
);

    localparam int ROM_DEPTH = FD / N_PE;
    localparam int KW        = width_of(ROM_DEPTH + 1);
    localparam int ROMW      = width_of(ROM_DEPTH);
    localparam int MAW       = width_of(H * W);

    state_t        r_state;
    logic [KW-1:0] r_k;
    logic          r_push_vld;
    logic          r_push_pad;
    logic          r_push_win;
    logic          r_push_last;
    logic          r_last_win;
    logic          r_frame_done;

    logic           w_issue;
    logic           w_clear;
    logic           w_is_pad;
    logic           w_win_done;
    logic           w_last_beat;
    logic [MAW-1:0] w_mem_addr;

    // Issuing pauses while a window-completing beat sits in the push stage
    assign w_issue = (r_state == ST_STREAM) && !r_push_win;
    assign w_clear = (r_state == ST_IDLE) && start;

    bcedn_raster_cnt #(
        .H    (H),
        .W    (W),
        .PAD  (PAD),
        .FH   (FH),
        .FW   (FW),
        .HP_P (H + 2 * PAD),
        .WP_P (W + 2 * PAD)
    ) u_raster (
        .clk         (clk),
        .rst         (rst),
        .i_advance   (w_issue),
        .i_clear     (w_clear),
        .o_is_pad    (w_is_pad),
        .o_win_done  (w_win_done),
        .o_last_beat (w_last_beat),
        .o_mem_addr  (w_mem_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_k          <= '0;
            r_push_vld   <= 1'b0;
            r_push_pad   <= 1'b0;
            r_push_win   <= 1'b0;
            r_push_last  <= 1'b0;
            r_last_win   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_push_vld   <= w_issue;
            r_push_pad   <= w_issue & w_is_pad;
            r_push_win   <= w_issue & w_win_done;
            r_push_last  <= w_issue & w_last_beat;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (r_push_win) begin
                        r_state    <= ST_COMPUTE;
                        r_k        <= '0;
                        r_last_win <= r_push_last;
                    end
                end
                ST_COMPUTE: begin
                    // One extra cycle drains the ROM read latency into the shift register
                    if (r_k == KW'(ROM_DEPTH)) begin
                        r_state <= ST_EMIT;
                        r_k     <= '0;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (r_last_win) begin
                            r_state      <= ST_IDLE;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state <= ST_STREAM;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_rd_en  = w_issue & ~w_is_pad;
    assign mem_addr   = mem_rd_en ? w_mem_addr : '0;
    assign pix_valid  = r_push_vld;
    assign pad_sel    = r_push_pad;
    assign pix_out    = (r_push_vld & ~r_push_pad) ? mem_rd_data : '0;
    assign rom_en     = (r_state == ST_COMPUTE) && (r_k < KW'(ROM_DEPTH));
    assign rom_addr   = rom_en ? r_k[ROMW-1:0] : '0;
    assign shreg_en   = (r_state == ST_COMPUTE) && (r_k != '0);
    assign vec_valid  = (r_state == ST_EMIT);
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;

endmodule
